// File: rtl/atm_bank_responder.sv
// Bank-side ATM responder: PIN and lockout checks, balance updates, and a
// shared history ring streamed newest-first as a per-account mini statement.
module atm_bank_responder #(
  parameter int unsigned NUM_ACCTS  = 4,
  parameter int unsigned PIN_BASE   = 1234,
  parameter logic [7:0]  INIT_BAL   = 8'd200,
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned MAX_TRIES  = 3,
  localparam int unsigned AW = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_acct,
  input  logic [15:0]   req_pin,
  input  logic [1:0]    req_op,
  input  logic [7:0]    req_amount,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2:0]    rsp_status,
  output logic [7:0]    rsp_old_balance,
  output logic [7:0]    rsp_new_balance,
  output logic          rsp_last
);

  localparam int unsigned PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int unsigned CW = $clog2(HIST_DEPTH + 1);
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_BAD_PIN      = 3'd1;
  localparam logic [2:0] ST_LOCKED       = 3'd2;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd3;
  localparam logic [2:0] ST_OVERFLOW     = 3'd4;
  localparam logic [2:0] ST_BAD_ACCT     = 3'd5;
  localparam logic [2:0] ST_NO_HISTORY   = 3'd6;

  localparam logic [1:0] OP_WITHDRAW = 2'd1;
  localparam logic [1:0] OP_DEPOSIT  = 2'd2;
  localparam logic [1:0] OP_MINI     = 2'd3;

  typedef enum logic [2:0] {IDLE, EXEC, RESP, SCAN, STREAM} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] lat_acct;
  logic [15:0]   lat_pin;
  logic [1:0]    lat_op;
  logic [7:0]    lat_amount;

  logic [7:0]           bal      [NUM_ACCTS];
  logic [FW-1:0]        fail_cnt [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock;

  logic [AW-1:0] hist_acct [HIST_DEPTH];
  logic [7:0]    hist_old  [HIST_DEPTH];
  logic [7:0]    hist_new  [HIST_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] hist_cnt;
  logic [CW-1:0] scan_idx;

  logic          bad_acct, pin_ok;
  logic [7:0]    cur_bal;
  logic [8:0]    sum9;
  logic [FW-1:0] fail_nxt;
  logic [2:0]    ex_status;
  logic [7:0]    ex_old, ex_new;
  logic          ex_commit, fail_inc, fail_clr;
  logic [PW-1:0] cur_pos;
  logic          scan_done, cur_match, more_match;

  // Ring slot holding the k-th newest entry (k = 0 is the most recent write).
  function automatic logic [PW-1:0] ring_pos(input logic [PW-1:0] wp, input int unsigned k);
    int unsigned p;
    p = (32'(wp) + 2 * HIST_DEPTH - 1 - k) % HIST_DEPTH;
    return PW'(p);
  endfunction

  assign req_ready = (state == IDLE);
  assign bad_acct  = (32'(lat_acct) >= NUM_ACCTS);
  assign pin_ok    = (lat_pin == 16'(PIN_BASE + 32'(lat_acct)));
  assign cur_bal   = bad_acct ? '0 : bal[lat_acct];
  assign sum9      = {1'b0, cur_bal} + {1'b0, lat_amount};
  assign fail_nxt  = fail_cnt[lat_acct] + 1'b1;
  assign cur_pos   = ring_pos(wr_ptr, 32'(scan_idx));
  assign scan_done = (scan_idx >= hist_cnt);
  assign cur_match = !scan_done && (hist_acct[cur_pos] == lat_acct);

  // Lookahead so the final matching beat can carry rsp_last.
  always_comb begin
    more_match = 1'b0;
    for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
      if (k > 32'(scan_idx) && k < 32'(hist_cnt) && hist_acct[ring_pos(wr_ptr, k)] == lat_acct)
        more_match = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ex_status = ST_OK;
    ex_old    = cur_bal;
    ex_new    = cur_bal;
    ex_commit = 1'b0;
    fail_inc  = 1'b0;
    fail_clr  = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = EXEC;
      EXEC: begin
        state_nxt = RESP;
        if (bad_acct) begin
          ex_status = ST_BAD_ACCT;
          ex_old    = '0;
          ex_new    = '0;
        end else if (lock[lat_acct]) begin
          ex_status = ST_LOCKED;
        end else if (!pin_ok) begin
          ex_status = ST_BAD_PIN;
          fail_inc  = 1'b1;
        end else begin
          fail_clr = 1'b1;
          case (lat_op)
            OP_WITHDRAW: begin
              if (lat_amount > cur_bal) ex_status = ST_INSUFFICIENT;
              else begin
                ex_new    = cur_bal - lat_amount;
                ex_commit = 1'b1;
              end
            end
            OP_DEPOSIT: begin
              if (sum9[8]) ex_status = ST_OVERFLOW;
              else begin
                ex_new    = sum9[7:0];
                ex_commit = 1'b1;
              end
            end
            OP_MINI: state_nxt = SCAN;
            default: ;
          endcase
        end
      end
      RESP:   if (rsp_valid && rsp_ready) state_nxt = IDLE;
      SCAN: begin
        if (scan_done)      state_nxt = RESP;
        else if (cur_match) state_nxt = STREAM;
      end
      STREAM: if (rsp_valid && rsp_ready) state_nxt = rsp_last ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rsp_valid       <= 1'b0;
      rsp_last        <= 1'b0;
      rsp_status      <= '0;
      rsp_old_balance <= '0;
      rsp_new_balance <= '0;
      lat_acct        <= '0;
      lat_pin         <= '0;
      lat_op          <= '0;
      lat_amount      <= '0;
      lock            <= '0;
      wr_ptr          <= '0;
      hist_cnt        <= '0;
      scan_idx        <= '0;
      for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
        bal[i]      <= INIT_BAL;
        fail_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_acct   <= req_acct;
            lat_pin    <= req_pin;
            lat_op     <= req_op;
            lat_amount <= req_amount;
          end
        end
        EXEC: begin
          // Result is parked here; rsp_valid rises one cycle later in RESP.
          rsp_status      <= ex_status;
          rsp_old_balance <= ex_old;
          rsp_new_balance <= ex_new;
          rsp_last        <= 1'b1;
          scan_idx        <= '0;
          if (fail_inc) begin
            fail_cnt[lat_acct] <= fail_nxt;
            if (fail_nxt >= FW'(MAX_TRIES)) lock[lat_acct] <= 1'b1;
          end
          if (fail_clr) fail_cnt[lat_acct] <= '0;
          if (ex_commit) begin
            bal[lat_acct]     <= ex_new;
            hist_acct[wr_ptr] <= lat_acct;
            hist_old[wr_ptr]  <= cur_bal;
            hist_new[wr_ptr]  <= ex_new;
            wr_ptr            <= (wr_ptr == PW'(HIST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (hist_cnt != CW'(HIST_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
          end
        end
        RESP: begin
          if (!rsp_valid) rsp_valid <= 1'b1;
          else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_done) begin
            rsp_status      <= ST_NO_HISTORY;
            rsp_old_balance <= cur_bal;
            rsp_new_balance <= cur_bal;
            rsp_last        <= 1'b1;
            rsp_valid       <= 1'b1;
          end else if (cur_match) begin
            rsp_status      <= ST_OK;
            rsp_old_balance <= hist_old[cur_pos];
            rsp_new_balance <= hist_new[cur_pos];
            rsp_last        <= !more_match;
            rsp_valid       <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        STREAM: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) rsp_last <= 1'b0;
            else          scan_idx <= scan_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Self-checking bench for atm_bank_responder against a transaction-level model
// of accounts, lockout and the 4-entry history ring.
module tb_atm_bank_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_acct = '0;
  logic [15:0] req_pin = '0;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_status;
  logic [7:0]  rsp_old_balance;
  logic [7:0]  rsp_new_balance;
  logic        rsp_last;

  always #5 clk = ~clk;

  atm_bank_responder #(
    .NUM_ACCTS(4), .PIN_BASE(1234), .INIT_BAL(8'd200), .HIST_DEPTH(4), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_acct(req_acct),
    .req_pin(req_pin), .req_op(req_op), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_old_balance(rsp_old_balance), .rsp_new_balance(rsp_new_balance),
    .rsp_last(rsp_last)
  );

  typedef struct packed {logic [2:0] st; logic [7:0] ob; logic [7:0] nb; logic last;} beat_t;
  typedef struct {int acct; int ob; int nb;} hent_t;
  typedef struct packed {logic rst_before; logic [1:0] a; logic [15:0] p; logic [1:0] o; logic [7:0] m;} stim_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  hent_t hist[$];
  int    m_bal[4];
  int    m_fail[4];
  bit    m_lock[4];
  int    checks = 0;
  int    errors = 0;
  bit    timeout, leak;
  int    first_lat;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bal[i] = 200; m_fail[i] = 0; m_lock[i] = 1'b0;
    end
    hist.delete();
  endfunction

  function automatic void push_exp(int st, int ob, int nb, bit last);
    beat_t t;
    t.st = 3'(st); t.ob = 8'(ob); t.nb = 8'(nb); t.last = last;
    exp_q.push_back(t);
  endfunction

  function automatic void log_hist(int a, int ob, int nb);
    hent_t h;
    h.acct = a; h.ob = ob; h.nb = nb;
    hist.push_back(h);
    if (hist.size() > 4) hist.delete(0);
  endfunction

  function automatic void model_txn(int a, int p, int o, int m);
    int    b;
    beat_t t;
    exp_q.delete();
    if (a >= 4) begin
      push_exp(5, 0, 0, 1'b1);
      return;
    end
    b = m_bal[a];
    if (m_lock[a]) push_exp(2, b, b, 1'b1);
    else if (p != 1234 + a) begin
      m_fail[a]++;
      if (m_fail[a] >= 3) m_lock[a] = 1'b1;
      push_exp(1, b, b, 1'b1);
    end else begin
      m_fail[a] = 0;
      case (o)
        0: push_exp(0, b, b, 1'b1);
        1: if (m > b) push_exp(3, b, b, 1'b1);
           else begin push_exp(0, b, b - m, 1'b1); log_hist(a, b, b - m); m_bal[a] = b - m; end
        2: if (b + m > 255) push_exp(4, b, b, 1'b1);
           else begin push_exp(0, b, b + m, 1'b1); log_hist(a, b, b + m); m_bal[a] = b + m; end
        default: begin
          for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].acct == a) push_exp(0, hist[i].ob, hist[i].nb, 1'b0);
          if (exp_q.size() == 0) push_exp(6, b, b, 1'b1);
          else begin
            t = exp_q.pop_back(); t.last = 1'b1; exp_q.push_back(t);
          end
        end
      endcase
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one request and collects every beat up to rsp_last (bounded).
  task automatic send(input logic [1:0] a, input logic [15:0] p, input logic [1:0] o,
                      input logic [7:0] m, input bit bp);
    int    n;
    bit    done;
    beat_t t;
    got_q.delete(); timeout = 1'b0; leak = 1'b0; first_lat = -1; done = 1'b0;
    req_acct = a; req_pin = p; req_op = o; req_amount = m; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req_ready) leak = 1'b1;
      if (rsp_valid && first_lat < 0) first_lat = n;
      if (rsp_valid && rsp_ready) begin
        t = '{rsp_status, rsp_old_balance, rsp_new_balance, rsp_last};
        got_q.push_back(t);
        done = rsp_last;
      end
      @(posedge clk); #1; n++;
    end
    rsp_ready = 1'b1;
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %0b exp 0", rsp_last); end
    checks++; if (rsp_status !== 3'd0) begin errors++; $display("FAIL reset_rsp_status got %0d exp 0", rsp_status); end
    checks++; if (rsp_old_balance !== 8'd0) begin errors++; $display("FAIL reset_old got %0d exp 0", rsp_old_balance); end
    checks++; if (rsp_new_balance !== 8'd0) begin errors++; $display("FAIL reset_new got %0d exp 0", rsp_new_balance); end
  endtask

  task automatic test_query();
    do_reset();
    send(2'd0, 16'd1234, 2'd0, 8'd0, 1'b0);
    model_txn(0, 1234, 0, 0);
    checks++;
    if (timeout || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL query beats=%0d timeout=%0b got %h exp %h", got_q.size(), timeout, got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
    end
    checks++; if (first_lat != 2) begin errors++; $display("FAIL query_latency got %0d exp 2", first_lat); end
    checks++; if (leak) begin errors++; $display("FAIL query_req_ready got 1 exp 0 while busy"); end
  endtask

  task automatic test_withdraw_deposit();
    stim_t s[$];
    s.push_back('{1'b1, 2'd1, 16'd1235, 2'd1, 8'd50});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd55});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd1, 8'd210});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd60});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd1, 8'd0});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd1, 8'd205});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd255});
    foreach (s[i]) begin
      if (s[i].rst_before) do_reset();
      send(s[i].a, s[i].p, s[i].o, s[i].m, 1'b0);
      model_txn(int'(s[i].a), int'(s[i].p), int'(s[i].o), int'(s[i].m));
      checks++;
      if (timeout || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL wd[%0d] beats got %0d exp %0d timeout=%0b", i, got_q.size(), exp_q.size(), timeout);
      end else foreach (exp_q[j]) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL wd[%0d] beat %0d got st=%0d old=%0d new=%0d last=%0b exp st=%0d old=%0d new=%0d last=%0b", i, j,
                   got_q[j].st, got_q[j].ob, got_q[j].nb, got_q[j].last, exp_q[j].st, exp_q[j].ob, exp_q[j].nb, exp_q[j].last);
        end
      end
    end
  endtask

  task automatic test_lockout();
    stim_t s[$];
    s.push_back('{1'b1, 2'd2, 16'd9999, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd2, 16'd9999, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd2, 16'd9999, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd2, 16'd1236, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd2, 16'd1236, 2'd1, 8'd10});
    s.push_back('{1'b0, 2'd3, 16'd1237, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd3, 16'd1, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd3, 16'd1237, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd3, 16'd1, 2'd0, 8'd0});
    s.push_back('{1'b0, 2'd3, 16'd1, 2'd0, 8'd0});
    s.push_back('{1'b1, 2'd2, 16'd1236, 2'd0, 8'd0});
    foreach (s[i]) begin
      if (s[i].rst_before) do_reset();
      send(s[i].a, s[i].p, s[i].o, s[i].m, 1'b0);
      model_txn(int'(s[i].a), int'(s[i].p), int'(s[i].o), int'(s[i].m));
      checks++;
      if (timeout || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL lock[%0d] beats got %0d exp %0d timeout=%0b", i, got_q.size(), exp_q.size(), timeout);
      end else foreach (exp_q[j]) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL lock[%0d] beat %0d got st=%0d old=%0d new=%0d last=%0b exp st=%0d old=%0d new=%0d last=%0b", i, j,
                   got_q[j].st, got_q[j].ob, got_q[j].nb, got_q[j].last, exp_q[j].st, exp_q[j].ob, exp_q[j].nb, exp_q[j].last);
        end
      end
    end
  endtask

  task automatic test_history();
    stim_t s[$];
    s.push_back('{1'b1, 2'd0, 16'd1234, 2'd1, 8'd10});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd1});
    s.push_back('{1'b0, 2'd0, 16'd1234, 2'd1, 8'd10});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd1});
    s.push_back('{1'b0, 2'd0, 16'd1234, 2'd1, 8'd10});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd2, 8'd1});
    s.push_back('{1'b0, 2'd0, 16'd1234, 2'd3, 8'd0});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd3, 8'd0});
    s.push_back('{1'b0, 2'd2, 16'd1236, 2'd3, 8'd0});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd1, 8'd0});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd1, 8'd0});
    s.push_back('{1'b0, 2'd1, 16'd1235, 2'd3, 8'd0});
    s.push_back('{1'b0, 2'd0, 16'd1234, 2'd3, 8'd0});
    foreach (s[i]) begin
      if (s[i].rst_before) do_reset();
      send(s[i].a, s[i].p, s[i].o, s[i].m, 1'b0);
      model_txn(int'(s[i].a), int'(s[i].p), int'(s[i].o), int'(s[i].m));
      checks++;
      if (timeout || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL hist[%0d] beats got %0d exp %0d timeout=%0b", i, got_q.size(), exp_q.size(), timeout);
      end else foreach (exp_q[j]) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL hist[%0d] beat %0d got st=%0d old=%0d new=%0d last=%0b exp st=%0d old=%0d new=%0d last=%0b", i, j,
                   got_q[j].st, got_q[j].ob, got_q[j].nb, got_q[j].last, exp_q[j].st, exp_q[j].ob, exp_q[j].nb, exp_q[j].last);
        end
      end
    end
  endtask

  task automatic test_hold();
    beat_t b0, now;
    int    n;
    do_reset();
    rsp_ready = 1'b0;
    req_acct = 2'd3; req_pin = 16'd1237; req_op = 2'd3; req_amount = 8'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_txn(3, 1237, 3, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    b0 = '{rsp_status, rsp_old_balance, rsp_new_balance, rsp_last};
    checks++;
    if (!rsp_valid || b0 !== exp_q[0]) begin
      errors++; $display("FAIL no_history valid=%0b got %h exp %h", rsp_valid, b0, exp_q[0]);
    end
    // A competing request must stay unaccepted while the beat is stalled.
    req_acct = 2'd0; req_pin = 16'd1234; req_op = 2'd1; req_amount = 8'd5; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      now = '{rsp_status, rsp_old_balance, rsp_new_balance, rsp_last};
      checks++;
      if (now !== b0 || !rsp_valid || req_ready) begin
        errors++; $display("FAIL hold[%0d] got %h valid=%0b ready=%0b exp %h valid=1 ready=0", c, now, rsp_valid, req_ready, b0);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got valid=%0b ready=%0b exp valid=0 ready=1", rsp_valid, req_ready);
    end
    send(2'd0, 16'd1234, 2'd0, 8'd0, 1'b0);
    model_txn(0, 1234, 0, 0);
    checks++;
    if (timeout || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL hold_no_accept beats=%0d got %h exp %h", got_q.size(), got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_reset_midstream();
    stim_t s[$];
    int    n;
    do_reset();
    send(2'd0, 16'd1234, 2'd2, 8'd1, 1'b0); model_txn(0, 1234, 2, 1);
    send(2'd0, 16'd1234, 2'd2, 8'd1, 1'b0); model_txn(0, 1234, 2, 1);
    rsp_ready = 1'b0;
    req_acct = 2'd0; req_pin = 16'd1234; req_op = 2'd3; req_amount = 8'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_txn(0, 1234, 3, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (!rsp_valid || rsp_last !== 1'b0 || rsp_old_balance !== exp_q[0].ob || rsp_new_balance !== exp_q[0].nb) begin
      errors++; $display("FAIL midstream_first valid=%0b last=%0b old=%0d new=%0d exp old=%0d new=%0d last=0", rsp_valid, rsp_last,
                         rsp_old_balance, rsp_new_balance, exp_q[0].ob, exp_q[0].nb);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    model_reset();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL midstream_reset got valid=%0b ready=%0b exp valid=0 ready=1", rsp_valid, req_ready);
    end
    s.push_back('{1'b0, 2'd0, 16'd1234, 2'd3, 8'd0});
    for (int a = 0; a < 4; a++) s.push_back('{1'b0, 2'(a), 16'(1234 + a), 2'd0, 8'd0});
    foreach (s[i]) begin
      send(s[i].a, s[i].p, s[i].o, s[i].m, 1'b0);
      model_txn(int'(s[i].a), int'(s[i].p), int'(s[i].o), int'(s[i].m));
      checks++;
      if (timeout || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL post_reset[%0d] beats=%0d got %h exp %h", i, got_q.size(), got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  a, o;
    logic [15:0] p;
    logic [7:0]  m;
    for (int i = 0; i < 80; i++) begin
      if (i % 25 == 0) do_reset();
      a = 2'($urandom_range(0, 3));
      o = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 5) == 0) ? 16'd9999 : 16'(1234 + int'(a));
      m = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 60));
      send(a, p, o, m, 1'b1);
      model_txn(int'(a), int'(p), int'(o), int'(m));
      checks++;
      if (timeout || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand[%0d] beats got %0d exp %0d timeout=%0b", i, got_q.size(), exp_q.size(), timeout);
      end else foreach (exp_q[j]) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL rand[%0d] beat %0d got st=%0d old=%0d new=%0d last=%0b exp st=%0d old=%0d new=%0d last=%0b", i, j,
                   got_q[j].st, got_q[j].ob, got_q[j].nb, got_q[j].last, exp_q[j].st, exp_q[j].ob, exp_q[j].nb, exp_q[j].last);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_query();
    test_withdraw_deposit();
    test_lockout();
    test_history();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
